// File: rtl/freq_meter_pkg.sv
// ---------------------------------------------------------------------------
// freq_meter_pkg
// Shared types and defaults for the frequency meter.
//   state_e             : FSM state encoding (IDLE, GATE, DONE)
//   DEF_GATE_CYCLES     : default gate window length in clk cycles
//   DEF_CNT_W           : default width of the edge counter / result
// ---------------------------------------------------------------------------
package freq_meter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GATE = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned DEF_GATE_CYCLES = 100000000;
    localparam int          DEF_CNT_W       = 32;

endpackage

// File: rtl/freq_meter_sync_edge_det.sv
// ---------------------------------------------------------------------------
// sync_edge_det
// Brings an asynchronous input into the clk domain through two flops, then
// flags each rising edge of the synchronized level with a one-cycle pulse.
// Ports:
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   din        : asynchronous input level
//   rise_pulse : one clk cycle high per rising edge of the synchronized din
// ---------------------------------------------------------------------------
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise_pulse
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = din;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise_pulse = sync_q & ~prev_q;

endmodule

// File: rtl/freq_meter.sv
// ---------------------------------------------------------------------------
// freq_meter
// Counts rising edges of sig_in over a gate window of GATE_CYCLES clk cycles
// and publishes the count with a one-cycle valid pulse.
// Parameters:
//   GATE_CYCLES : gate length in clk cycles (2 .. 2^32-1)
//   CNT_W       : width of the edge counter and of freq_out / period_out
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   sig_in      : measured signal, asynchronous to clk
//   start       : one-cycle request to begin a measurement (ignored while busy)
//   cont        : continuous mode, re-arm a new gate after every result
//   busy        : high in GATE and DONE
//   valid       : one-cycle pulse, freq_out/overflow carry a new result
//   freq_out    : edge count of the last completed gate (saturating)
//   overflow    : the last result saturated
//   period_out  : (FREQ_METER_PERIOD_EN only) clk cycles between the last
//                 two edges of the gate, 0 if fewer than two edges
// Optional feature macro: FREQ_METER_PERIOD_EN
// Handshake: valid is a pure strobe with no ready; the result registers are
// already updated in the cycle valid is high and hold until the next strobe.
// ---------------------------------------------------------------------------
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = DEF_GATE_CYCLES,
    parameter int          CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             start,
    input  logic             cont,
    output logic             busy,
    output logic             valid,
    output logic [CNT_W-1:0] freq_out,
    output logic             overflow
`ifdef FREQ_METER_PERIOD_EN
    ,
    output logic [CNT_W-1:0] period_out
`endif
);

    localparam logic [31:0]      GATE_LAST = 32'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_e           state_q, state_d;
    logic [31:0]      gate_cnt_q, gate_cnt_d;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d, edge_cnt_inc;
    logic             ovf_q, ovf_d, ovf_inc;
    logic [CNT_W-1:0] freq_q, freq_d;
    logic             overflow_q, overflow_d;
    logic             edge_pulse;
    logic             gate_last;
    logic             gate_enter;

    sync_edge_det u_sync_edge_det (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (sig_in),
        .rise_pulse(edge_pulse)
    );

    assign gate_last = (gate_cnt_q == GATE_LAST);

    // Saturating edge count including the current cycle's pulse.
    always_comb begin
        edge_cnt_inc = edge_cnt_q;
        ovf_inc      = ovf_q;
        if (edge_pulse) begin
            if (edge_cnt_q == CNT_MAX) begin
                ovf_inc = 1'b1;
            end else begin
                edge_cnt_inc = edge_cnt_q + CNT_W'(1);
            end
        end
    end

    // The result is captured on the GATE->DONE transition (using the count
    // that includes the terminal cycle), so it is visible while valid is high.
    always_comb begin
        state_d    = state_q;
        gate_cnt_d = gate_cnt_q;
        edge_cnt_d = edge_cnt_q;
        ovf_d      = ovf_q;
        freq_d     = freq_q;
        overflow_d = overflow_q;
        gate_enter = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) gate_enter = 1'b1;
            end
            GATE: begin
                edge_cnt_d = edge_cnt_inc;
                ovf_d      = ovf_inc;
                gate_cnt_d = gate_cnt_q + 32'd1;
                if (gate_last) begin
                    state_d    = DONE;
                    freq_d     = edge_cnt_inc;
                    overflow_d = ovf_inc;
                end
            end
            DONE: begin
                if (cont) gate_enter = 1'b1;
                else      state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (gate_enter) begin
            state_d    = GATE;
            gate_cnt_d = '0;
            edge_cnt_d = '0;
            ovf_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            ovf_q      <= 1'b0;
            freq_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            gate_cnt_q <= gate_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            ovf_q      <= ovf_d;
            freq_q     <= freq_d;
            overflow_q <= overflow_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign valid    = (state_q == DONE);
    assign freq_out = freq_q;
    assign overflow = overflow_q;

`ifdef FREQ_METER_PERIOD_EN
    // since_q: cycles elapsed since the last edge pulse (1 in the cycle
    // after the edge), so at the next edge it equals the edge spacing.
    logic [CNT_W-1:0] since_q, since_d, since_inc;
    logic [CNT_W-1:0] last_per_q, last_per_d, per_next;
    logic [CNT_W-1:0] period_q, period_d;
    logic             have_edge_q, have_edge_d;

    always_comb begin
        since_inc   = (since_q == CNT_MAX) ? since_q : since_q + CNT_W'(1);
        per_next    = last_per_q;
        since_d     = since_inc;
        last_per_d  = last_per_q;
        have_edge_d = have_edge_q;
        period_d    = period_q;
        if (edge_pulse && have_edge_q) per_next = since_q;
        if (state_q == GATE) begin
            last_per_d = per_next;
            if (edge_pulse) begin
                have_edge_d = 1'b1;
                since_d     = CNT_W'(1);
            end
            if (gate_last) period_d = per_next;
        end
        if (gate_enter) begin
            since_d     = '0;
            last_per_d  = '0;
            have_edge_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            since_q     <= '0;
            last_per_q  <= '0;
            period_q    <= '0;
            have_edge_q <= 1'b0;
        end else begin
            since_q     <= since_d;
            last_per_q  <= last_per_d;
            period_q    <= period_d;
            have_edge_q <= have_edge_d;
        end
    end

    assign period_out = period_q;
`endif

endmodule

// File: tb/tb_freq_meter.sv
// ---------------------------------------------------------------------------
// tb_freq_meter
// Directed bench for freq_meter with GATE_CYCLES=100. Two instances share all
// inputs: dut (CNT_W=16) and dut4 (CNT_W=4, for the saturation case).
// ---------------------------------------------------------------------------
module tb_freq_meter;

    localparam int GC = 100;

    logic        clk;
    logic        rst_n;
    logic        sig_in;
    logic        start;
    logic        cont;
    logic        busy, valid, overflow;
    logic [15:0] freq_out;
    logic        busy4, valid4, overflow4;
    logic [3:0]  freq_out4;
`ifdef FREQ_METER_PERIOD_EN
    logic [15:0] period_out;
    logic [3:0]  period_out4;
`endif

    int total = 0;
    int bad   = 0;
    int sig_mode = 0;
    int ph = 0;

    freq_meter #(.GATE_CYCLES(GC), .CNT_W(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sig_in  (sig_in),
        .start   (start),
        .cont    (cont),
        .busy    (busy),
        .valid   (valid),
        .freq_out(freq_out),
        .overflow(overflow)
`ifdef FREQ_METER_PERIOD_EN
        ,
        .period_out(period_out)
`endif
    );

    freq_meter #(.GATE_CYCLES(GC), .CNT_W(4)) dut4 (
        .clk     (clk),
        .rst_n   (rst_n),
        .sig_in  (sig_in),
        .start   (start),
        .cont    (cont),
        .busy    (busy4),
        .valid   (valid4),
        .freq_out(freq_out4),
        .overflow(overflow4)
`ifdef FREQ_METER_PERIOD_EN
        ,
        .period_out(period_out4)
`endif
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // sig_in generator: 0 = held low, 2 = toggles every cycle, 10 = period 10
    always @(negedge clk) begin
        ph = ph + 1;
        case (sig_mode)
            2:       sig_in = ph[0];
            10:      sig_in = ((ph % 10) < 5);
            default: sig_in = 1'b0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // Counts clk edges after the start-sampling edge until valid is seen.
    // Optionally re-pulses start so it is sampled at edge restart_at+1.
    task automatic wait_valid(input int restart_at, output int k, output int busy_low);
        k = 0;
        busy_low = 0;
        while (k < 400) begin
            @(posedge clk);
            #1;
            k++;
            start = (k == restart_at);
            if (valid) break;
            if (!busy) busy_low++;
        end
        start = 1'b0;
    endtask

    initial begin
        int k;
        int bl;
        int nv;

        rst_n  = 1'b0;
        start  = 1'b0;
        cont   = 1'b0;
        sig_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_valid", valid, 0);
        check("rst_freq", freq_out, 0);
        check("rst_ovf", overflow, 0);
        @(negedge clk) rst_n = 1'b1;

        // sig_in idle: count 0, latency GC+1 counted from the start cycle
        repeat (10) @(posedge clk);
        do_start();
        wait_valid(0, k, bl);
        check("idle_lat", k + 1, GC + 1);
        check("idle_freq", freq_out, 0);
        check("idle_ovf", overflow, 0);
        check("idle_busy_gate", bl, 0);
        check("idle_busy_done", busy, 1);
        @(posedge clk);
        #1;
        check("idle_valid_1cyc", valid, 0);
        check("idle_to_idle", busy, 0);

        // period-10 signal: exactly 10 rising edges in any 100 cycles
        sig_mode = 10;
        repeat (30) @(posedge clk);
        do_start();
        wait_valid(0, k, bl);
        check("p10_lat", k + 1, GC + 1);
        check("p10_freq", freq_out, 10);
        check("p10_ovf", overflow, 0);
        check("p10_freq4", freq_out4, 10);
        check("p10_ovf4", overflow4, 0);
`ifdef FREQ_METER_PERIOD_EN
        check("p10_period", period_out, 10);
`endif
        repeat (20) @(posedge clk);
        #1;
        check("p10_hold_freq", freq_out, 10);
        check("p10_hold_valid", valid, 0);

        // toggle every cycle: 50 edges, CNT_W=4 saturates at 15
        sig_mode = 2;
        repeat (30) @(posedge clk);
        do_start();
        wait_valid(0, k, bl);
        check("tog_freq", freq_out, 50);
        check("tog_ovf", overflow, 0);
        check("tog_valid4", valid4, 1);
        check("tog_freq4", freq_out4, 15);
        check("tog_ovf4", overflow4, 1);
`ifdef FREQ_METER_PERIOD_EN
        check("tog_period", period_out, 2);
`endif

        // continuous mode for three gates
        sig_mode = 10;
        repeat (30) @(posedge clk);
        cont = 1'b1;
        do_start();
        wait_valid(0, k, bl);
        check("cont_lat1", k + 1, GC + 1);
        check("cont_ovf1", overflow, 0);
        wait_valid(0, k, bl);
        check("cont_gap2", k, GC + 1);
        check("cont_busy2", bl, 0);
        check("cont_freq2", freq_out, 10);
        @(posedge clk);
        #1;
        check("cont_busy_regate", busy, 1);
        cont = 1'b0;
        wait_valid(0, k, bl);
        check("cont_gap3", k + 1, GC + 1);
        check("cont_busy3", bl, 0);
        @(posedge clk);
        #1;
        check("cont_stop", busy, 0);
        repeat (20) @(posedge clk);
        #1;
        check("cont_stay_idle", busy, 0);

        // start again mid-gate is ignored
        do_start();
        wait_valid(49, k, bl);
        check("restart_lat", k + 1, GC + 1);
        check("restart_freq", freq_out, 10);

        // reset at cycle 60 of a gate
        do_start();
        repeat (59) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_freq", freq_out, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        nv = 0;
        repeat (200) begin
            @(posedge clk);
            #1;
            if (valid) nv++;
        end
        check("mid_rst_novalid", nv, 0);
        check("mid_rst_freq_hold", freq_out, 0);
        check("mid_rst_idle", busy, 0);
        do_start();
        wait_valid(0, k, bl);
        check("post_rst_lat", k + 1, GC + 1);
        check("post_rst_freq", freq_out, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
